// File: rtl/hi_lo_multiply_divide_unit.sv
// HI/LO register file with an iterative (one bit per cycle) multiply/divide engine.
// Also handles MTHI/MTLO, and stalls any HI/LO access that collides with an operation in flight.
module hi_lo_multiply_divide_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  instruction_valid,
   input  logic [5:0]            funct,
   input  logic                  HI_register_write,
   input  logic                  LO_register_write,
   input  logic                  using_HI_LO,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] HI_out,
   output logic [DATA_WIDTH-1:0] LO_out,
   output logic                  done
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

   localparam logic [5:0] FUNCT_MTHI = 6'b010001;
   localparam logic [5:0] FUNCT_MTLO = 6'b010011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic [2*W-1:0] acc_reg;            // upper: partial product / remainder, lower: multiplier / quotient
   logic [W-1:0]   mcand_reg;          // multiplicand or divisor magnitude
   logic [W-1:0]   dividend_raw_reg;
   logic           neg_result_reg;
   logic           neg_rem_reg;
   logic           div_zero_reg;
   logic           is_div_reg;
   logic [CW-1:0]  counter_reg;
   logic [W-1:0]   hi_reg;
   logic [W-1:0]   lo_reg;
   logic           done_reg;

   logic           start;
   logic           mthi;
   logic           mtlo;
   logic           busy;
   logic           accept;
   logic           op_signed;
   logic           op_div;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;

   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_step;
   logic [W:0]     div_shift;
   logic [W:0]     div_diff;
   logic [2*W-1:0] div_step;
   logic [W-1:0]   fix_hi;
   logic [W-1:0]   fix_lo;

   // ---------------- decode and stall ----------------
   always_comb begin
      start  = instruction_valid & HI_register_write & LO_register_write
               & (funct[5:2] == 4'b0110);
      mthi   = instruction_valid & HI_register_write & ~LO_register_write
               & (funct == FUNCT_MTHI);
      mtlo   = instruction_valid & LO_register_write & ~HI_register_write
               & (funct == FUNCT_MTLO);
      busy   = (state_reg != IDLE);
      stall  = busy & (start | mthi | mtlo | (instruction_valid & using_HI_LO));
      accept = start & ~busy;
      // funct[0]=1 selects the unsigned variant, funct[1]=1 selects divide
      op_signed = ~funct[0];
      op_div    = funct[1];
   end

   always_comb begin
      mag_a = operand_a;
      mag_b = operand_b;
      if (op_signed && operand_a[W-1]) begin
         mag_a = -operand_a;
      end
      if (op_signed && operand_b[W-1]) begin
         mag_b = -operand_b;
      end
   end

   // ---------------- one iteration of each engine ----------------
   always_comb begin
      mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
      mul_step  = {mul_sum, acc_reg[W-1:1]};

      div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
      div_diff  = div_shift - {1'b0, mcand_reg};
      if (div_diff[W]) begin
         div_step = {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
      end else begin
         div_step = {div_diff[W-1:0], acc_reg[W-2:0], 1'b1};
      end
   end

   // ---------------- sign correction of the magnitude result ----------------
   always_comb begin
      fix_hi = acc_reg[2*W-1:W];
      fix_lo = acc_reg[W-1:0];
      if (!is_div_reg) begin
         if (neg_result_reg) begin
            {fix_hi, fix_lo} = -acc_reg;
         end
      end else if (div_zero_reg) begin
         fix_hi = dividend_raw_reg;
         fix_lo = '1;
      end else begin
         if (neg_result_reg) begin
            fix_lo = -acc_reg[W-1:0];
         end
         if (neg_rem_reg) begin
            fix_hi = -acc_reg[2*W-1:W];
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = op_div ? DIV : MUL;
            end
         end
         MUL, DIV: begin
            if (counter_reg == LAST_ITER) begin
               state_next = FIX;
            end
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_reg          <= '0;
         mcand_reg        <= '0;
         dividend_raw_reg <= '0;
         neg_result_reg   <= 1'b0;
         neg_rem_reg      <= 1'b0;
         div_zero_reg     <= 1'b0;
         is_div_reg       <= 1'b0;
         counter_reg      <= '0;
         hi_reg           <= '0;
         lo_reg           <= '0;
         done_reg         <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  acc_reg          <= {{W{1'b0}}, mag_a};
                  mcand_reg        <= mag_b;
                  dividend_raw_reg <= operand_a;
                  neg_result_reg   <= op_signed & (operand_a[W-1] ^ operand_b[W-1]);
                  neg_rem_reg      <= op_signed & operand_a[W-1];
                  div_zero_reg     <= (operand_b == '0);
                  is_div_reg       <= op_div;
                  counter_reg      <= '0;
               end else begin
                  if (mthi) begin
                     hi_reg <= operand_a;
                  end
                  if (mtlo) begin
                     lo_reg <= operand_a;
                  end
               end
            end
            MUL: begin
               acc_reg     <= mul_step;
               counter_reg <= counter_reg + 1'b1;
            end
            DIV: begin
               acc_reg     <= div_step;
               counter_reg <= counter_reg + 1'b1;
            end
            FIX: begin
               hi_reg      <= fix_hi;
               lo_reg      <= fix_lo;
               done_reg    <= 1'b1;
               counter_reg <= '0;
            end
            default: ;
         endcase
      end
   end

   assign HI_out = hi_reg;
   assign LO_out = lo_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Randomized self-checking bench for hi_lo_multiply_divide_unit against a plain-arithmetic model.
module tb_hi_lo_multiply_divide_unit;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instruction_valid;
   logic [5:0]  funct;
   logic        HI_register_write;
   logic        LO_register_write;
   logic        using_HI_LO;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        stall;
   logic [31:0] HI_out;
   logic [31:0] LO_out;
   logic        done;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   hi_lo_multiply_divide_unit #(.DATA_WIDTH(32)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .instruction_valid (instruction_valid),
      .funct             (funct),
      .HI_register_write (HI_register_write),
      .LO_register_write (LO_register_write),
      .using_HI_LO       (using_HI_LO),
      .operand_a         (operand_a),
      .operand_b         (operand_b),
      .stall             (stall),
      .HI_out            (HI_out),
      .LO_out            (LO_out),
      .done              (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // Reference: {HI, LO} for an op, from ordinary 64-bit arithmetic.
   function automatic logic [63:0] ref_hilo(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, ua, ub, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      res = '0;
      case (f)
         F_MULT:  res = sa * sb;
         F_MULTU: res = ua * ub;
         default: begin
            if (b == 32'h0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = (f == F_DIV) ? sa / sb : ua / ub;
               r = (f == F_DIV) ? sa % sb : ua % ub;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   task automatic set_bubble();
      instruction_valid = 1'b0;
      funct             = 6'd0;
      HI_register_write = 1'b0;
      LO_register_write = 1'b0;
      using_HI_LO       = 1'b0;
   endtask

   // Issues an op at the current negedge, exercises stall during the busy window with random
   // reads and junk operands, and returns at the negedge of the done cycle.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input string name);
      logic [63:0] expv;
      int k;
      bit  exp_stall;
      expv = ref_hilo(f, a, b);
      instruction_valid = 1'b1;
      funct = f;
      HI_register_write = 1'b1;
      LO_register_write = 1'b1;
      using_HI_LO = 1'b0;
      operand_a = a;
      operand_b = b;
      #1;
      total++;
      if (stall !== 1'b0) $display("FAIL %s issue_stall: got %b want 0", name, stall);
      else passed++;
      @(negedge clk);
      k = 0;
      while (k < 40) begin
         instruction_valid = 1'b1;
         HI_register_write = 1'b0;
         LO_register_write = 1'b0;
         funct = 6'($urandom);
         using_HI_LO = 1'($urandom);
         operand_a = $urandom;
         operand_b = $urandom;
         #1;
         exp_stall = (k < 33) ? using_HI_LO : 1'b0;
         total++;
         if (stall !== exp_stall)
            $display("FAIL %s stall_k%0d: got %b want %b", name, k, stall, exp_stall);
         else passed++;
         if (done === 1'b1) break;
         @(negedge clk);
         k++;
      end
      set_bubble();
      total++;
      if (k !== 33) $display("FAIL %s done_latency: got %0d want 33", name, k);
      else passed++;
      exp_hi = expv[63:32];
      exp_lo = expv[31:0];
      total++;
      if (HI_out !== exp_hi) $display("FAIL %s hi: got %h want %h", name, HI_out, exp_hi);
      else passed++;
      total++;
      if (LO_out !== exp_lo) $display("FAIL %s lo: got %h want %h", name, LO_out, exp_lo);
      else passed++;
      $display("op %s f=%b a=%h b=%h -> HI=%h LO=%h", name, f, a, b, HI_out, LO_out);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_bubble();
      operand_a = '0;
      operand_b = '0;
      repeat (3) @(negedge clk);
      instruction_valid = 1'b1;
      using_HI_LO = 1'b1;
      #1;
      total++;
      if (HI_out !== 32'h0) $display("FAIL reset_hi: got %h want 0", HI_out); else passed++;
      total++;
      if (LO_out !== 32'h0) $display("FAIL reset_lo: got %h want 0", LO_out); else passed++;
      total++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
      reset_n = 1'b1;
      set_bubble();
      @(negedge clk);
      $display("reset checked");
   endtask

   task automatic test_spec_vectors();
      logic [5:0]  fv[6];
      logic [31:0] av[6];
      logic [31:0] bv[6];
      fv = '{F_MULT, F_MULTU, F_DIVU, F_DIV, F_DIV, F_DIV};
      av = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
      bv = '{32'd5, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         run_op(fv[i], av[i], bv[i], $sformatf("vec%0d", i));
         @(negedge clk);
         total++;
         if (done !== 1'b0) $display("FAIL vec%0d done_pulse: got %b want 0", i, done);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [5:0]  fs[4];
      logic [5:0]  f;
      logic [31:0] a, b;
      int sel;
      fs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      for (int i = 0; i < 24; i++) begin
         f = fs[$urandom_range(0, 3)];
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'h0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = b >> $urandom_range(8, 31);
         run_op(f, a, b, $sformatf("rand%0d", i));
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      run_op(F_MULTU, $urandom, $urandom, "b2b0");
      run_op(F_DIV, $urandom, $urandom_range(1, 1000), "b2b1");
      run_op(F_MULT, $urandom, $urandom, "b2b2");
      @(negedge clk);
      total++;
      if (done !== 1'b0) $display("FAIL b2b done_pulse: got %b want 0", done); else passed++;
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] v;
      instruction_valid = 1'b1;
      funct = F_MTHI;
      HI_register_write = 1'b1;
      LO_register_write = 1'b0;
      operand_a = 32'h0000_1234;
      #1;
      total++;
      if (stall !== 1'b0) $display("FAIL mthi_stall: got %b want 0", stall); else passed++;
      @(negedge clk);
      set_bubble();
      exp_hi = 32'h0000_1234;
      total++;
      if (HI_out !== exp_hi) $display("FAIL mthi_hi: got %h want %h", HI_out, exp_hi); else passed++;
      total++;
      if (LO_out !== exp_lo) $display("FAIL mthi_lo: got %h want %h", LO_out, exp_lo); else passed++;
      total++;
      if (done !== 1'b0) $display("FAIL mthi_done: got %b want 0", done); else passed++;
      v = $urandom;
      instruction_valid = 1'b1;
      funct = F_MTLO;
      LO_register_write = 1'b1;
      operand_a = v;
      @(negedge clk);
      set_bubble();
      exp_lo = v;
      total++;
      if (LO_out !== exp_lo) $display("FAIL mtlo_lo: got %h want %h", LO_out, exp_lo); else passed++;
      total++;
      if (HI_out !== exp_hi) $display("FAIL mtlo_hi: got %h want %h", HI_out, exp_hi); else passed++;
      total++;
      if (done !== 1'b0) $display("FAIL mtlo_done: got %b want 0", done); else passed++;
      $display("mthi/mtlo HI=%h LO=%h", HI_out, LO_out);
   endtask

   // MTHI held by upstream while a MULT is in flight: stalls, then lands after the product.
   task automatic test_mthi_held();
      logic [63:0] expv;
      logic [31:0] a, b;
      int k;
      a = $urandom;
      b = $urandom;
      expv = ref_hilo(F_MULT, a, b);
      instruction_valid = 1'b1;
      funct = F_MULT;
      HI_register_write = 1'b1;
      LO_register_write = 1'b1;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
      funct = F_MTHI;
      LO_register_write = 1'b0;
      operand_a = 32'h0000_ABCD;
      k = 0;
      #1;
      while (stall === 1'b1 && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      total++;
      if (k !== 33) $display("FAIL held_stall_len: got %0d want 33", k); else passed++;
      total++;
      if (done !== 1'b1) $display("FAIL held_done: got %b want 1", done); else passed++;
      total++;
      if (HI_out !== expv[63:32]) $display("FAIL held_hi_prod: got %h want %h", HI_out, expv[63:32]);
      else passed++;
      @(negedge clk);
      set_bubble();
      exp_hi = 32'h0000_ABCD;
      exp_lo = expv[31:0];
      total++;
      if (HI_out !== exp_hi) $display("FAIL held_hi_mthi: got %h want %h", HI_out, exp_hi); else passed++;
      total++;
      if (LO_out !== exp_lo) $display("FAIL held_lo: got %h want %h", LO_out, exp_lo); else passed++;
      $display("mthi held over MULT: HI=%h LO=%h", HI_out, LO_out);
   endtask

   task automatic test_reset_midop();
      instruction_valid = 1'b1;
      funct = F_MULT;
      HI_register_write = 1'b1;
      LO_register_write = 1'b1;
      operand_a = 32'h1234_5678;
      operand_b = 32'h9ABC_DEF0;
      @(negedge clk);
      set_bubble();
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      instruction_valid = 1'b1;
      using_HI_LO = 1'b1;
      #1;
      exp_hi = '0;
      exp_lo = '0;
      total++;
      if (stall !== 1'b0) $display("FAIL midreset_stall: got %b want 0", stall); else passed++;
      total++;
      if (HI_out !== 32'h0) $display("FAIL midreset_hi: got %h want 0", HI_out); else passed++;
      total++;
      if (LO_out !== 32'h0) $display("FAIL midreset_lo: got %h want 0", LO_out); else passed++;
      total++;
      if (done !== 1'b0) $display("FAIL midreset_done: got %b want 0", done); else passed++;
      reset_n = 1'b1;
      set_bubble();
      @(negedge clk);
      $display("reset mid-MULT checked");
      run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, "after_reset");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_mthi_mtlo();
      test_back_to_back();
      test_mthi_held();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
